// File: rtl/axi_lite_to_dma_pipe_if.sv
// AXI4-Lite slave channels plus the DMA request/response pins of the bridge, bundled as one port.
// "slave" is the bridge's view; "master" is the view of whatever drives the AXI side and models the DMA.
interface axi_lite_to_dma_pipe_if #(
  parameter int addr_width_p = 64,
  parameter int data_width_p = 64
);
  logic                      awvalid_i;
  logic [addr_width_p-1:0]   awaddr_i;
  logic                      awready_o;
  logic                      wvalid_i;
  logic [data_width_p/8-1:0] wstrb_i;
  logic [data_width_p-1:0]   wdata_i;
  logic                      wready_o;
  logic                      bvalid_o;
  logic [1:0]                bresp_o;
  logic                      bready_i;
  logic                      arvalid_i;
  logic [addr_width_p-1:0]   araddr_i;
  logic                      arready_o;
  logic                      rvalid_o;
  logic [data_width_p-1:0]   rdata_o;
  logic [1:0]                rresp_o;
  logic                      rready_i;
  logic                      ready_i;
  logic                      v_o;
  logic                      we_o;
  logic [addr_width_p-1:0]   addr_o;
  logic [data_width_p/8-1:0] be_o;
  logic [data_width_p-1:0]   data_o;
  logic                      v_i;
  logic [data_width_p-1:0]   data_i;
  logic                      ready_o;

  modport slave (
    input  awvalid_i, awaddr_i, wvalid_i, wstrb_i, wdata_i, bready_i,
    input  arvalid_i, araddr_i, rready_i, ready_i, v_i, data_i,
    output awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o, rdata_o, rresp_o,
    output v_o, we_o, addr_o, be_o, data_o, ready_o
  );

  modport master (
    output awvalid_i, awaddr_i, wvalid_i, wstrb_i, wdata_i, bready_i,
    output arvalid_i, araddr_i, rready_i, ready_i, v_i, data_i,
    input  awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o, rdata_o, rresp_o,
    input  v_o, we_o, addr_o, be_o, data_o, ready_o
  );
endinterface

// File: rtl/axi_lite_to_dma_pipe.sv
// AXI4-Lite slave to single-port DMA request bridge; zero-cycle request path, in-order responses.
// Backpressure: AW/W/AR stall on a full response FIFO or (for legal addresses) on ready_i low.

module axi_lite_to_dma_pipe_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] dat_i,
  input  logic               pop_i,
  output logic [width_p-1:0] dat_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [ptr_w_lp:0]   r_cnt;

  // Caller never pushes when full nor pops when empty, so no guarding here.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= dat_i;
  end

  assign dat_o   = r_mem[r_rptr];
  assign full_o  = (r_cnt == (ptr_w_lp+1)'(els_p));
  assign empty_o = (r_cnt == '0);
endmodule

module axi_lite_to_dma_pipe #(
  parameter int              addr_width_p = 64,
  parameter int              data_width_p = 64,
  parameter int              els_p        = 4,
  parameter longint unsigned addr_limit_p = 64'h1_0000_0000
) (
  input logic                    clk_i,
  input logic                    reset_i,
  axi_lite_to_dma_pipe_if.slave  bus
);
  localparam logic [64:0] limit_lp = 65'(addr_limit_p);

  typedef enum logic {PRI_W, PRI_R} pri_e;

  pri_e        r_pri;
  pri_e        w_pri_nxt;
  logic        w_aw_err;
  logic        w_ar_err;
  logic        w_w_elig;
  logic        w_r_elig;
  logic        w_grant_w;
  logic        w_grant_r;
  logic        w_b_full;
  logic        w_b_empty;
  logic        w_b_pop;
  logic [1:0]  w_b_head;
  logic        w_t_full;
  logic        w_t_empty;
  logic        w_t_pop;
  logic        w_t_head;

  assign w_aw_err = (65'(bus.awaddr_i) >= limit_lp);
  assign w_ar_err = (65'(bus.araddr_i) >= limit_lp);

  // Decode-error requests never reach the DMA, so they must not wait on ready_i.
  assign w_w_elig = !reset_i && bus.awvalid_i && bus.wvalid_i && !w_b_full
                    && (w_aw_err || bus.ready_i);
  assign w_r_elig = !reset_i && bus.arvalid_i && !w_t_full
                    && (w_ar_err || bus.ready_i);

  assign w_grant_w = w_w_elig && (!w_r_elig || (r_pri == PRI_W));
  assign w_grant_r = w_r_elig && !w_grant_w;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_pri <= PRI_W;
    else         r_pri <= w_pri_nxt;
  end

  // Priority only flips on contended cycles; an uncontended grant leaves it alone.
  always_comb begin
    w_pri_nxt = r_pri;
    if (w_w_elig && w_r_elig) begin
      w_pri_nxt = w_grant_w ? PRI_R : PRI_W;
    end
  end

  assign bus.awready_o = w_grant_w;
  assign bus.wready_o  = w_grant_w;
  assign bus.arready_o = w_grant_r;

  assign bus.v_o    = (w_grant_w && !w_aw_err) || (w_grant_r && !w_ar_err);
  assign bus.we_o   = w_grant_w;
  assign bus.addr_o = w_grant_w ? bus.awaddr_i : bus.araddr_i;
  assign bus.be_o   = bus.wstrb_i;
  assign bus.data_o = bus.wdata_i;

  axi_lite_to_dma_pipe_fifo #(.width_p(2), .els_p(els_p)) u_b_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_grant_w),
    .dat_i   (w_aw_err ? 2'b11 : 2'b00),
    .pop_i   (w_b_pop),
    .dat_o   (w_b_head),
    .full_o  (w_b_full),
    .empty_o (w_b_empty)
  );

  assign bus.bvalid_o = !w_b_empty;
  assign bus.bresp_o  = w_b_head;
  assign w_b_pop      = !w_b_empty && bus.bready_i;

  axi_lite_to_dma_pipe_fifo #(.width_p(1), .els_p(els_p)) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_grant_r),
    .dat_i   (w_ar_err),
    .pop_i   (w_t_pop),
    .dat_o   (w_t_head),
    .full_o  (w_t_full),
    .empty_o (w_t_empty)
  );

  // An error tag at the head answers on its own; a legal one waits for the DMA beat.
  assign bus.rvalid_o = !w_t_empty && (w_t_head || bus.v_i);
  assign bus.rdata_o  = (!w_t_empty && !w_t_head) ? bus.data_i : '0;
  assign bus.rresp_o  = (!w_t_empty && w_t_head) ? 2'b11 : 2'b00;
  assign bus.ready_o  = !w_t_empty && !w_t_head && bus.rready_i;
  assign w_t_pop      = !w_t_empty && bus.rready_i && (w_t_head || bus.v_i);
endmodule
